// File: rtl/axi4_burst_traffic_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_burst_traffic_gen_if
// Brief    : AXI4 full-protocol bundle between the traffic generator and a slave
// Revision : 1.0 - initial release
// ============================================================================
interface axi4_burst_traffic_gen_if #(
    parameter int addr_width_p = 28,
    parameter int data_width_p = 64,
    parameter int id_width_p   = 4
);
    logic [id_width_p-1:0]     awid;
    logic [addr_width_p-1:0]   awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      awlock;
    logic [3:0]                awcache;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;

    logic [data_width_p-1:0]   wdata;
    logic [data_width_p/8-1:0] wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;

    logic [id_width_p-1:0]     bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    logic [id_width_p-1:0]     arid;
    logic [addr_width_p-1:0]   araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arlock;
    logic [3:0]                arcache;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;

    logic [id_width_p-1:0]     rid;
    logic [data_width_p-1:0]   rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface
`default_nettype wire

// File: rtl/axi4_burst_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : axi4_burst_traffic_gen
// Brief    : AXI4 INCR-burst memory self-test master: write pattern, read, check
// Revision : 1.0 - initial release
// ============================================================================
module axi4_burst_traffic_gen #(
    parameter int          addr_width_p = 28,
    parameter int          data_width_p = 64,
    parameter int          id_width_p   = 4,
    parameter int          burst_len_p  = 4,
    parameter int          num_bursts_p = 16,
    parameter logic [63:0] base_addr_p  = 64'h0,
    parameter logic [31:0] seed_p       = 32'h1
) (
    input  wire logic                clk_i,
    input  wire logic                reset_n_i,
    input  wire logic                start_i,
    input  wire logic [1:0]          mode_i,
    axi4_burst_traffic_gen_if.master axi,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     wr_error_o,
    output logic                     rd_error_o,
    output logic [15:0]              err_count_o
);
    localparam int c_bytes   = data_width_p / 8;
    localparam int c_reps    = data_width_p / 32;
    localparam int c_beat_w  = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
    localparam int c_burst_w = (num_bursts_p > 1) ? $clog2(num_bursts_p) : 1;

    localparam logic [c_beat_w-1:0]     c_last_beat   = c_beat_w'(burst_len_p - 1);
    localparam logic [c_burst_w-1:0]    c_last_burst  = c_burst_w'(num_bursts_p - 1);
    localparam logic [addr_width_p-1:0] c_base        = addr_width_p'(base_addr_p);
    localparam logic [addr_width_p-1:0] c_burst_bytes = addr_width_p'(burst_len_p * c_bytes);
    localparam logic [addr_width_p-1:0] c_beat_bytes  = addr_width_p'(c_bytes);
    localparam logic [2:0]              c_size        = 3'($clog2(c_bytes));

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_DATA = 3'd2,
        S_WR_RESP = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_DATA = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_wr_only;
    logic [c_beat_w-1:0]     r_beat;
    logic [c_burst_w-1:0]    r_burst;
    logic                    r_done;
    logic                    r_wr_err;
    logic                    r_rd_err;
    logic [15:0]             r_err_count;

    logic                    w_start;
    logic                    w_last_beat;
    logic                    w_last_burst;
    logic                    w_w_hs;
    logic                    w_b_hs;
    logic                    w_r_hs;
    logic                    w_b_err;
    logic                    w_r_err;
    logic [addr_width_p-1:0] w_burst_addr;
    logic [addr_width_p-1:0] w_beat_addr;
    logic [31:0]             w_pat32;
    logic [data_width_p-1:0] w_pattern;

    assign w_start      = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last_beat  = (r_beat == c_last_beat);
    assign w_last_burst = (r_burst == c_last_burst);
    assign w_w_hs       = axi.wvalid && axi.wready;
    assign w_b_hs       = axi.bvalid && axi.bready;
    assign w_r_hs       = axi.rvalid && axi.rready;

    // Addresses wrap at addr_width_p; the pattern sees the zero-extended low 32 bits.
    assign w_burst_addr = c_base + addr_width_p'(r_burst) * c_burst_bytes;
    assign w_beat_addr  = w_burst_addr + addr_width_p'(r_beat) * c_beat_bytes;
    assign w_pat32      = 32'(w_beat_addr) ^ seed_p;
    assign w_pattern    = {c_reps{w_pat32}};

    assign w_b_err = w_b_hs && ((axi.bresp != 2'b00) || (axi.bid != '0));
    assign w_r_err = w_r_hs && ((axi.rresp != 2'b00) || (axi.rid != '0) ||
                                (axi.rdata != w_pattern) || (axi.rlast != w_last_beat));

    assign axi.awid    = '0;
    assign axi.awaddr  = w_burst_addr;
    assign axi.awlen   = 8'(burst_len_p - 1);
    assign axi.awsize  = c_size;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 1'b0;
    assign axi.awcache = 4'b0011;
    assign axi.awprot  = 3'b000;
    assign axi.wdata   = w_pattern;
    assign axi.wstrb   = '1;
    assign axi.wlast   = w_last_beat;
    assign axi.arid    = '0;
    assign axi.araddr  = w_burst_addr;
    assign axi.arlen   = 8'(burst_len_p - 1);
    assign axi.arsize  = c_size;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 1'b0;
    assign axi.arcache = 4'b0011;
    assign axi.arprot  = 3'b000;

    always_comb begin
        w_state_nxt = r_state;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    w_state_nxt = (mode_i == 2'd2) ? S_RD_ADDR : S_WR_ADDR;
                end
            end
            S_WR_ADDR: begin
                axi.awvalid = 1'b1;
                if (axi.awready) w_state_nxt = S_WR_DATA;
            end
            S_WR_DATA: begin
                axi.wvalid = 1'b1;
                if (axi.wready && w_last_beat) w_state_nxt = S_WR_RESP;
            end
            S_WR_RESP: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    if (!w_last_burst) w_state_nxt = S_WR_ADDR;
                    else               w_state_nxt = r_wr_only ? S_DONE : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                axi.arvalid = 1'b1;
                if (axi.arready) w_state_nxt = S_RD_DATA;
            end
            S_RD_DATA: begin
                axi.rready = 1'b1;
                if (axi.rvalid && w_last_beat) begin
                    w_state_nxt = w_last_burst ? S_DONE : S_RD_ADDR;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= S_IDLE;
            r_wr_only   <= 1'b0;
            r_beat      <= '0;
            r_burst     <= '0;
            r_done      <= 1'b0;
            r_wr_err    <= 1'b0;
            r_rd_err    <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_wr_only   <= (mode_i == 2'd1);
                r_beat      <= '0;
                r_burst     <= '0;
                r_done      <= 1'b0;
                r_wr_err    <= 1'b0;
                r_rd_err    <= 1'b0;
                r_err_count <= '0;
            end else begin
                // The beat counter alone ends a burst; rlast is only checked.
                if (w_w_hs || w_r_hs) begin
                    r_beat <= w_last_beat ? '0 : r_beat + c_beat_w'(1);
                end
                if (w_b_hs || (w_r_hs && w_last_beat)) begin
                    r_burst <= w_last_burst ? '0 : r_burst + c_burst_w'(1);
                end
                if (w_b_err) r_wr_err <= 1'b1;
                if (w_r_err) r_rd_err <= 1'b1;
                if ((w_b_err || w_r_err) && (r_err_count != 16'hFFFF)) begin
                    r_err_count <= r_err_count + 16'd1;
                end
                if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) r_done <= 1'b1;
            end
        end
    end

    assign busy_o      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done_o      = r_done;
    assign wr_error_o  = r_wr_err;
    assign rd_error_o  = r_rd_err;
    assign err_count_o = r_err_count;
endmodule
`default_nettype wire

// File: tb/tb_axi4_burst_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_burst_traffic_gen
// Brief    : Directed bench with AXI slave memory model and expected-beat queues
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_burst_traffic_gen;
    localparam int c_aw = 28;
    localparam int c_dw = 64;
    localparam int c_iw = 4;
    localparam int c_bl = 4;
    localparam int c_nb = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode  = 2'd0;
    logic        busy, done, wr_err, rd_err;
    logic [15:0] errc;

    int total = 0;
    int bad   = 0;

    axi4_burst_traffic_gen_if #(.addr_width_p(c_aw), .data_width_p(c_dw), .id_width_p(c_iw)) bus ();

    axi4_burst_traffic_gen #(
        .addr_width_p(c_aw), .data_width_p(c_dw), .id_width_p(c_iw),
        .burst_len_p(c_bl), .num_bursts_p(c_nb), .base_addr_p(64'h0), .seed_p(32'h1)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .mode_i(mode), .axi(bus),
        .busy_o(busy), .done_o(done), .wr_error_o(wr_err), .rd_error_o(rd_err),
        .err_count_o(errc)
    );

    always #5 clk = ~clk;

    // Stimulus knobs and slave-model state
    bit  rand_rdy = 1'b0;
    bit  bresp_bad = 1'b0;
    int  corrupt_burst = -1, corrupt_beat = 0, early_burst = -1, early_beat = 0;
    logic [c_dw-1:0] mem [int];
    logic [c_aw-1:0] q_aw[$];
    logic [c_aw-1:0] q_ar[$];
    logic [c_dw:0]   q_w[$];
    logic [c_aw-1:0] w_base, r_base, aw_hold, ar_hold;
    logic [c_dw:0]   w_hold;
    logic [c_dw-1:0] rd_word;
    int  w_beat, r_beat, r_left, ar_cnt, rb;
    bit  b_pending, b_fire, r_fire, aw_stall, w_stall, ar_stall;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy();
        return rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    function automatic logic [c_aw-1:0] baddr(input int k);
        return c_aw'(k * c_bl * (c_dw / 8));
    endfunction

    function automatic logic [c_dw-1:0] pat(input logic [c_aw-1:0] a);
        logic [31:0] v;
        v = 32'(a) ^ 32'h1;
        return {v, v};
    endfunction

    // Slave model: acts at the falling edge, so every handshake it decides on
    // completes at the following rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
            bus.bvalid = 1'b0; bus.bid = '0; bus.bresp = 2'b00;
            bus.rvalid = 1'b0; bus.rid = '0; bus.rdata = '0; bus.rresp = 2'b00; bus.rlast = 1'b0;
            mem.delete();
            w_beat = 0; r_beat = 0; r_left = 0; ar_cnt = 0;
            b_pending = 1'b0; b_fire = 1'b0; r_fire = 1'b0;
            aw_stall = 1'b0; w_stall = 1'b0; ar_stall = 1'b0;
        end else begin
            if (aw_stall) chk("aw_hold", {bus.awvalid, bus.awaddr}, {1'b1, aw_hold});
            if (w_stall)  chk("w_hold", {bus.wvalid, bus.wlast, bus.wdata}, {1'b1, w_hold});
            if (ar_stall) chk("ar_hold", {bus.arvalid, bus.araddr}, {1'b1, ar_hold});

            if (b_fire) begin bus.bvalid = 1'b0; b_fire = 1'b0; end
            if (!bus.bvalid && b_pending && rdy()) begin
                bus.bvalid = 1'b1;
                bus.bresp  = bresp_bad ? 2'b10 : 2'b00;
                b_pending  = 1'b0;
            end
            b_fire = bus.bvalid && bus.bready;

            if (r_fire) begin bus.rvalid = 1'b0; r_fire = 1'b0; r_beat++; r_left--; end
            if (!bus.rvalid && r_left > 0 && rdy()) begin
                rb = (ar_cnt - 1) % c_nb;
                rd_word = mem.exists(int'((r_base + c_aw'(r_beat * 8)) >> 3)) ?
                          mem[int'((r_base + c_aw'(r_beat * 8)) >> 3)] : '0;
                if (rb == corrupt_burst && r_beat == corrupt_beat) rd_word = rd_word ^ 64'h0001_0000;
                bus.rdata  = rd_word;
                bus.rlast  = (rb == early_burst) ? (r_beat == early_beat) : (r_beat == c_bl - 1);
                bus.rvalid = 1'b1;
            end
            r_fire = bus.rvalid && bus.rready;

            bus.awready = rdy();
            aw_stall = bus.awvalid && !bus.awready;
            aw_hold  = bus.awaddr;
            if (bus.awvalid && bus.awready) begin
                chk("aw_expected", q_aw.size() != 0, 1'b1);
                if (q_aw.size() != 0) chk("aw_addr", bus.awaddr, q_aw.pop_front());
                chk("aw_fields", {bus.awid, bus.awlen, bus.awsize, bus.awburst, bus.awlock, bus.awcache, bus.awprot},
                                 {4'h0, 8'd3, 3'd3, 2'b01, 1'b0, 4'b0011, 3'b000});
                w_base = bus.awaddr;
                w_beat = 0;
            end

            bus.wready = rdy();
            w_stall = bus.wvalid && !bus.wready;
            w_hold  = {bus.wlast, bus.wdata};
            if (bus.wvalid && bus.wready) begin
                chk("w_expected", q_w.size() != 0, 1'b1);
                if (q_w.size() != 0) chk("w_beat", {bus.wlast, bus.wdata}, q_w.pop_front());
                chk("w_strb", bus.wstrb, 8'hFF);
                mem[int'((w_base + c_aw'(w_beat * 8)) >> 3)] = bus.wdata;
                w_beat++;
                if (w_beat == c_bl) begin b_pending = 1'b1; w_beat = 0; end
            end

            bus.arready = rdy();
            ar_stall = bus.arvalid && !bus.arready;
            ar_hold  = bus.araddr;
            if (bus.arvalid && bus.arready) begin
                chk("ar_expected", q_ar.size() != 0, 1'b1);
                if (q_ar.size() != 0) chk("ar_addr", bus.araddr, q_ar.pop_front());
                chk("ar_fields", {bus.arid, bus.arlen, bus.arsize, bus.arburst, bus.arlock, bus.arcache, bus.arprot},
                                 {4'h0, 8'd3, 3'd3, 2'b01, 1'b0, 4'b0011, 3'b000});
                r_base = bus.araddr;
                r_beat = 0;
                r_left = c_bl;
                ar_cnt++;
            end
        end
    end

    task automatic run_pass(input logic [1:0] m);
        for (int k = 0; k < c_nb; k++) begin
            if (m != 2'd2) begin
                q_aw.push_back(baddr(k));
                for (int b = 0; b < c_bl; b++) begin
                    q_w.push_back({(b == c_bl - 1), pat(baddr(k) + c_aw'(b * 8))});
                end
            end
            if (m != 2'd1) q_ar.push_back(baddr(k));
        end
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_result(input string tag, input logic w, input logic r, input logic [15:0] c);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_wr_error"}, wr_err, w);
        chk({tag, "_rd_error"}, rd_err, r);
        chk({tag, "_err_count"}, errc, c);
        chk({tag, "_leftover_beats"}, 32'(q_aw.size() + q_w.size() + q_ar.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {busy, done, wr_err, rd_err, errc, bus.awvalid, bus.wvalid,
                              bus.bready, bus.arvalid, bus.rready}, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        run_pass(2'd0);
        wait_done();
        check_result("basic", 1'b0, 1'b0, 16'd0);
        chk("basic_beat1_wdata", mem.exists(1) ? mem[1] : '0, 64'h00000009_00000009);

        rand_rdy = 1'b1;
        run_pass(2'd0);
        wait_done();
        check_result("backpressure", 1'b0, 1'b0, 16'd0);
        rand_rdy = 1'b0;

        corrupt_burst = 3; corrupt_beat = 2;
        run_pass(2'd0);
        wait_done();
        check_result("corrupt", 1'b0, 1'b1, 16'd1);
        corrupt_burst = -1;

        bresp_bad = 1'b1;
        run_pass(2'd1);
        wait_done();
        check_result("bresp", 1'b1, 1'b0, 16'd16);
        bresp_bad = 1'b0;

        early_burst = 0; early_beat = 1;
        run_pass(2'd0);
        wait_done();
        check_result("early_rlast", 1'b0, 1'b1, 16'd2);
        early_burst = -1;

        run_pass(2'd0);
        for (int n = 0; n < 200 && !bus.wvalid; n++) @(negedge clk);
        chk("reset_reach_wdata", bus.wvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midburst_reset_outputs", {busy, done, wr_err, rd_err, errc, bus.awvalid, bus.wvalid,
                                       bus.bready, bus.arvalid, bus.rready}, '0);
        repeat (2) @(negedge clk);
        q_aw.delete(); q_w.delete(); q_ar.delete();
        #2 rst_n = 1'b1;

        run_pass(2'd2);
        repeat (5) @(negedge clk);
        chk("readonly_busy", busy, 1'b1);
        mode  = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        check_result("readonly", 1'b0, 1'b1, 16'd64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
